mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on magnitudes, with sign fix-up applied in a final cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod;

  // op[0] clear selects the signed variants (MULT, DIV).
  assign neg_a = ~op[0] & operand_a[WIDTH-1];
  assign neg_b = ~op[0] & operand_b[WIDTH-1];
  assign a_mag = neg_a ? -operand_a : operand_a;
  assign b_mag = neg_b ? -operand_b : operand_b;

  // Multiply: acc_hi holds the running upper half, acc_lo shifts out multiplier bits.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    a_raw_d    = a_raw_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCalc;
          cnt_d      = '0;
          is_div_d   = op[1];
          neg_res_d  = neg_a ^ neg_b;
          neg_rem_d  = neg_a;
          div_zero_d = op[1] && (operand_b == '0);
          a_raw_d    = operand_a;
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_hi_d   = '0;
          acc_lo_d   = op[1] ? a_mag : b_mag;
        end else begin
          if (hi_write) hi_d = write_data;
          if (lo_write) lo_d = write_data;
        end
      end
      StCalc: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = StFinish;
      end
      StFinish: begin
        if (is_div_q) begin
          if (div_zero_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
          end
        end else begin
          {hi_d, lo_d} = neg_res_q ? -prod : prod;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      a_raw_q    <= a_raw_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level reference model compared every cycle, directed
// literal cases for signed/unsigned corners, interference, and asynchronous reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic [31:0] write_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .write_data(write_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the instruction semantics.
  function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      2'd2: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      default: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
    endcase
  endfunction

  // Reference model: cycles remaining until completion, pending result, architectural HI/LO.
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0;
  logic [31:0] c_hi, c_lo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end else if (start) begin
        calc(op, operand_a, operand_b, c_hi, c_lo);
        p_hi  <= c_hi;
        p_lo  <= c_lo;
        m_rem <= 33;
      end else begin
        if (hi_write) m_hi <= write_data;
        if (lo_write) m_lo <= write_data;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_rem != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  end

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a negedge; issues an op and checks its literal result and latency.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit intf,
                        input string name);
    int n, busy_cnt;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; operand_a = $urandom; operand_b = $urandom;
    n = 0; busy_cnt = 0;
    while (!done && n < 50) begin
      if (busy) busy_cnt++;
      if (intf && n == 9) begin
        start = 1'b1; op = 2'd1; operand_a = 32'h55; operand_b = 32'h77;
        hi_write = 1'b1; write_data = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; hi_write = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; hi_write = 1'b0;
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_m7x3");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, "mult_min2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7d2");
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100d7");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf");
    run_op(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, "divu_by0");
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, "div_neg_by0");
    run_op(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, "mult_interfere");

    // MTHI and MTLO in the same idle cycle.
    hi_write = 1'b1; lo_write = 1'b1; write_data = 32'hCAFE_0001;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    chk("mthi_mtlo_hi", 64'(hi), 64'h0000_0000_CAFE_0001);
    chk("mthi_mtlo_lo", 64'(lo), 64'h0000_0000_CAFE_0001);

    // Start beats a simultaneous MTHI.
    hi_write = 1'b1; write_data = 32'h1234;
    run_op(2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "start_wins");

    // Asynchronous reset mid-divide, then a fresh op on the first clean edge.
    start = 1'b1; op = 2'd2; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "after_rst");

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom % 8) == 0;
      op         = 2'($urandom);
      operand_a  = pick();
      operand_b  = pick();
      hi_write   = ($urandom % 5) == 0;
      lo_write   = ($urandom % 5) == 0;
      write_data = $urandom;
      rst        = ($urandom % 700) == 0;
      @(negedge clk);
    end
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
